// File: rtl/fp64_to_fp16_arb_if.sv
// Bundle of the requester-side and response-side signals of the shared FP64->FP16 converter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high. req_ready is
// a same-cycle grant derived from req_valid. rsp_valid never waits on rsp_ready and rsp_* hold while stalled.
interface fp64_to_fp16_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/fp64_to_fp16_arb.sv
// Round-robin arbiter feeding NUM_REQ requesters into one FP64->FP16 converter through
// a two-stage valid/ready pipeline (S1 operand, S2 result).

// Combinational FP64 -> FP16 conversion: truncating, overflow to infinity, NaN quieted.
module fp64_to_fp16 (
  input  logic [63:0] a,
  output logic [15:0] y
);
  logic        sign;
  logic [10:0] exp_f;
  logic [51:0] man_f;
  logic [10:0] sub_sh;
  logic [9:0]  sub_man;
  logic [4:0]  e16;

  assign sign  = a[63];
  assign exp_f = a[62:52];
  assign man_f = a[51:0];

  // Results below 2^-14 become FP16 subnormals: significand scaled to units of 2^-24.
  assign sub_sh  = 11'd1051 - exp_f;
  assign sub_man = 10'({1'b1, man_f} >> sub_sh);
  assign e16     = 5'(exp_f - 11'd1008);

  always_comb begin
    y = {sign, 15'h0};
    if (exp_f == 11'h7FF) begin
      y = (man_f != 52'h0) ? {sign, 5'h1F, 1'b1, man_f[50:42]} : {sign, 5'h1F, 10'h0};
    end else if (exp_f > 11'd1038) begin
      y = {sign, 5'h1F, 10'h0};
    end else if (exp_f >= 11'd1009) begin
      y = {sign, e16, man_f[51:42]};
    end else if (exp_f >= 11'd998) begin
      y = {sign, 5'h0, sub_man};
    end
  end
endmodule

module fp64_to_fp16_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic               clk,
  input logic               rst_n,
  fp64_to_fp16_arb_if.slave bus
);
  localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_REQ);

  logic            v1, v2;
  logic [63:0]     s1_data;
  logic [ID_W-1:0] s1_id;
  logic [15:0]     s2_data;
  logic [ID_W-1:0] s2_id;
  logic [ID_W-1:0] ptr;

  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      cand;
  logic [63:0]        gnt_data;
  logic [ID_W:0]      ptr_inc;
  logic [ID_W-1:0]    nxt_ptr;
  logic [NUM_REQ-1:0] ready_vec;
  logic [15:0]        conv_y;
  logic               adv1, load2, accept;

  fp64_to_fp16 u_conv (
    .a (s1_data),
    .y (conv_y)
  );

  assign load2  = v1 && (!v2 || bus.rsp_ready);
  assign adv1   = !v1 || !v2 || bus.rsp_ready;
  assign accept = gnt_valid && adv1;

  // Scan requesters starting at ptr and wrapping at NUM_REQ; first valid one wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = {1'b0, ptr};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_valid && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
      cand = cand + (ID_W+1)'(1);
      if (cand == NUM_W) cand = '0;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) gnt_data = bus.req_data[64*i +: 64];
    end
  end

  assign ptr_inc = {1'b0, gnt_idx} + (ID_W+1)'(1);
  assign nxt_ptr = (ptr_inc == NUM_W) ? '0 : ptr_inc[ID_W-1:0];

  // Grant is suppressed during reset so nothing is reported accepted while state is cleared.
  always_comb begin
    ready_vec = '0;
    if (rst_n && accept) ready_vec[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      s1_data <= '0;
      s1_id   <= '0;
      s2_data <= '0;
      s2_id   <= '0;
      ptr     <= '0;
    end else begin
      if (load2) begin
        s2_data <= conv_y;
        s2_id   <= s1_id;
        v2      <= 1'b1;
      end else if (v2 && bus.rsp_ready) begin
        v2 <= 1'b0;
      end
      if (accept) begin
        s1_data <= gnt_data;
        s1_id   <= gnt_idx;
        v1      <= 1'b1;
        ptr     <= nxt_ptr;
      end else if (load2) begin
        v1 <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = v2;
  assign bus.rsp_data  = s2_data;
  assign bus.rsp_id    = s2_id;
  assign bus.busy      = v1 || v2;
endmodule
